// File: rtl/mux_scan_sequencer.sv
// Scan sequencer for a 4-to-1 mux: steps sel through every channel, holds each
// for a programmable dwell, samples the mux output and assembles a scan word.
module mux_scan_sequencer #(
    parameter int DWELL_W = 4,
    parameter int NUM_CH  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               cont,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               y_in,
    output logic [1:0]         sel,
    output logic [3:0]         data_out,
    output logic               done,
    output logic               busy
);

    typedef enum logic {IDLE, SCAN} state_t;

    localparam logic [1:0] LAST_CH = 2'(NUM_CH - 1);

    state_t             state, state_nxt;
    logic [DWELL_W-1:0] count;
    logic [DWELL_W-1:0] dwell_q;
    logic [2:0]         shadow;
    logic               win_end;
    logic               last_ch;

    assign win_end = (count == '0);
    assign last_ch = (sel == LAST_CH);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SCAN;
            SCAN:    if (win_end && last_ch && !cont) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == SCAN);
    end

    // Datapath: dwell counter, channel select, per-channel sample shadow.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel      <= 2'd0;
            data_out <= 4'd0;
            done     <= 1'b0;
            shadow   <= 3'd0;
            count    <= '0;
            dwell_q  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    sel <= 2'd0;
                    if (start) begin
                        dwell_q <= dwell;
                        count   <= dwell;
                    end
                end
                SCAN: begin
                    if (!win_end) begin
                        count <= count - DWELL_W'(1);
                    end else if (!last_ch) begin
                        case (sel)
                            2'd0:    shadow[0] <= y_in;
                            2'd1:    shadow[1] <= y_in;
                            default: shadow[2] <= y_in;
                        endcase
                        sel   <= sel + 2'd1;
                        count <= dwell_q;
                    end else begin
                        // Restart in continuous mode reuses the dwell latched at start.
                        data_out <= {y_in, shadow};
                        done     <= 1'b1;
                        sel      <= 2'd0;
                        count    <= dwell_q;
                    end
                end
                default: sel <= 2'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Bench for mux_scan_sequencer: a mux model feeds y_in, and a timing model
// derived from scan-start edge arithmetic predicts sel/done/busy/data_out.
module tb_mux_scan_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       cont = 1'b0;
    logic [3:0] dwell = 4'd0;
    logic       y_in;
    logic [1:0] sel;
    logic [3:0] data_out;
    logic       done;
    logic       busy;
    logic [3:0] mux_i = 4'd0;

    int n_tests = 0;
    int n_fail  = 0;

    mux_scan_sequencer #(.DWELL_W(4), .NUM_CH(4)) dut (
        .clk(clk), .rst(rst), .start(start), .cont(cont), .dwell(dwell),
        .y_in(y_in), .sel(sel), .data_out(data_out), .done(done), .busy(busy)
    );

    assign y_in = mux_i[sel];

    always #5 clk = ~clk;

    // Reference: channel k of a scan started at edge E0 is sampled at
    // E0+(k+1)*(dwell+1); sel after edge E0+p is p/(dwell+1).
    int         cyc = 0;
    logic       m_busy = 1'b0;
    int         m_e0 = 0;
    int         m_len = 1;
    logic [3:0] m_word = 4'd0;
    logic [1:0] exp_sel = 2'd0;
    logic       exp_done = 1'b0;
    logic [3:0] exp_data = 4'd0;

    always @(posedge clk) begin
        int p, k;
        cyc++;
        exp_done = 1'b0;
        if (rst) begin
            m_busy = 1'b0; exp_sel = 2'd0; exp_data = 4'd0; m_word = 4'd0;
        end else if (!m_busy) begin
            exp_sel = 2'd0;
            if (start) begin
                m_busy = 1'b1; m_e0 = cyc; m_len = int'(dwell) + 1;
            end
        end else begin
            p = cyc - m_e0;
            if (p % m_len == 0) begin
                k = p / m_len - 1;
                m_word[k] = mux_i[k];
                if (k == 3) begin
                    exp_data = m_word; exp_done = 1'b1; exp_sel = 2'd0;
                    if (cont) m_e0 = cyc;
                    else      m_busy = 1'b0;
                end else begin
                    exp_sel = 2'(k + 1);
                end
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({sel, done, busy, data_out} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_state: sel/done/busy/data got %b/%b/%b/%b want 0/0/0/0", sel, done, busy, data_out);
        end
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({sel, done, busy} !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_idle: sel/done/busy got %b/%b/%b want 0/0/0", sel, done, busy);
        end
    endtask

    task automatic test_dwell0();
        int done_at = -1;
        mux_i = 4'b1010; dwell = 4'd0; cont = 1'b0; start = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 0) start = 1'b0;
            n_tests++;
            if ({sel, done, busy, data_out} !== {exp_sel, exp_done, m_busy, exp_data}) begin
                n_fail++;
                $display("FAIL dwell0 i=%0d: sel/done/busy/data got %h want %h", i,
                         {sel, done, busy, data_out}, {exp_sel, exp_done, m_busy, exp_data});
            end
            if (done && done_at < 0) done_at = i;
        end
        n_tests++;
        if (done_at !== 4 || data_out !== 4'b1010) begin
            n_fail++;
            $display("FAIL dwell0_result: done_at=%0d data=%b want 4 and 1010", done_at, data_out);
        end
    endtask

    task automatic test_dwell3_toggle();
        int done_at = -1;
        mux_i = 4'b0110; dwell = 4'd3; start = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 0) start = 1'b0;
            n_tests++;
            if ({sel, done, busy, data_out} !== {exp_sel, exp_done, m_busy, exp_data}) begin
                n_fail++;
                $display("FAIL dwell3 i=%0d: sel/done/busy/data got %h want %h", i,
                         {sel, done, busy, data_out}, {exp_sel, exp_done, m_busy, exp_data});
            end
            if (done && done_at < 0) done_at = i;
            if (i >= 4 && i <= 6) mux_i[1] = ~mux_i[1];
            if (i == 7) mux_i[1] = 1'b1;
        end
        n_tests++;
        if (done_at !== 16 || data_out !== 4'b0110) begin
            n_fail++;
            $display("FAIL dwell3_result: done_at=%0d data=%b want 16 and 0110", done_at, data_out);
        end
    endtask

    task automatic test_restart_ignored();
        int dones = 0;
        int done_at = -1;
        mux_i = 4'b0101; dwell = 4'd0; start = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            start = (i == 1);
            n_tests++;
            if ({sel, done, busy, data_out} !== {exp_sel, exp_done, m_busy, exp_data}) begin
                n_fail++;
                $display("FAIL restart i=%0d: sel/done/busy/data got %h want %h", i,
                         {sel, done, busy, data_out}, {exp_sel, exp_done, m_busy, exp_data});
            end
            if (done) begin dones++; if (done_at < 0) done_at = i; end
        end
        n_tests++;
        if (dones !== 1 || done_at !== 4 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_result: dones=%0d done_at=%0d busy=%b want 1, 4, 0", dones, done_at, busy);
        end
    endtask

    task automatic test_cont();
        int dones = 0;
        mux_i = 4'b0001; dwell = 4'd1; cont = 1'b1; start = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 0) start = 1'b0;
            n_tests++;
            if ({sel, done, busy, data_out} !== {exp_sel, exp_done, m_busy, exp_data}) begin
                n_fail++;
                $display("FAIL cont i=%0d: sel/done/busy/data got %h want %h", i,
                         {sel, done, busy, data_out}, {exp_sel, exp_done, m_busy, exp_data});
            end
            if (done) dones++;
            if (i == 8) begin
                n_tests++;
                if ({done, busy, data_out} !== 6'b11_0001) begin
                    n_fail++;
                    $display("FAIL cont_first: done/busy/data got %b/%b/%b want 1/1/0001", done, busy, data_out);
                end
                mux_i = 4'b1000;
            end
            if (i == 12) cont = 1'b0;
            if (i == 16) begin
                n_tests++;
                if ({done, busy, data_out} !== 6'b10_1000) begin
                    n_fail++;
                    $display("FAIL cont_second: done/busy/data got %b/%b/%b want 1/0/1000", done, busy, data_out);
                end
            end
        end
        n_tests++;
        if (dones !== 2) begin
            n_fail++;
            $display("FAIL cont_count: dones=%0d want 2", dones);
        end
    endtask

    task automatic test_reset_midscan();
        int dones = 0;
        int done_at = -1;
        mux_i = 4'b1111; dwell = 4'd2; start = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 0) start = 1'b0;
            if (i == 2) rst = 1'b1;
            if (i == 3) begin
                rst = 1'b0;
                n_tests++;
                if ({sel, done, busy, data_out} !== 8'h00) begin
                    n_fail++;
                    $display("FAIL midscan_reset: sel/done/busy/data got %b/%b/%b/%b want 0/0/0/0",
                             sel, done, busy, data_out);
                end
            end
            if (done) dones++;
        end
        n_tests++;
        if (dones !== 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midscan_nodone: dones=%0d busy=%b want 0 and 0", dones, busy);
        end
        mux_i = 4'b1001; start = 1'b1;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (i == 0) start = 1'b0;
            n_tests++;
            if ({sel, done, busy, data_out} !== {exp_sel, exp_done, m_busy, exp_data}) begin
                n_fail++;
                $display("FAIL post_reset i=%0d: sel/done/busy/data got %h want %h", i,
                         {sel, done, busy, data_out}, {exp_sel, exp_done, m_busy, exp_data});
            end
            if (done && done_at < 0) done_at = i;
        end
        n_tests++;
        if (done_at !== 12 || data_out !== 4'b1001) begin
            n_fail++;
            $display("FAIL post_reset_result: done_at=%0d data=%b want 12 and 1001", done_at, data_out);
        end
    endtask

    task automatic test_dwell_max();
        int done_at = -1;
        logic [1:0] sel_at [4];
        mux_i = 4'b0011; dwell = 4'hF; start = 1'b1;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            if (i == 0) start = 1'b0;
            dwell = 4'($urandom);
            n_tests++;
            if ({sel, done, busy, data_out} !== {exp_sel, exp_done, m_busy, exp_data}) begin
                n_fail++;
                $display("FAIL dwell_max i=%0d: sel/done/busy/data got %h want %h", i,
                         {sel, done, busy, data_out}, {exp_sel, exp_done, m_busy, exp_data});
            end
            if (done && done_at < 0) done_at = i;
            if (i == 15) sel_at[0] = sel;
            if (i == 16) sel_at[1] = sel;
            if (i == 32) sel_at[2] = sel;
            if (i == 48) sel_at[3] = sel;
        end
        n_tests++;
        if (done_at !== 64 || data_out !== 4'b0011 ||
            {sel_at[0], sel_at[1], sel_at[2], sel_at[3]} !== 8'b00_01_10_11) begin
            n_fail++;
            $display("FAIL dwell_max_result: done_at=%0d data=%b sel@15/16/32/48=%0d/%0d/%0d/%0d want 64, 0011, 0/1/2/3",
                     done_at, data_out, sel_at[0], sel_at[1], sel_at[2], sel_at[3]);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            n_tests++;
            if ({sel, done, busy, data_out} !== {exp_sel, exp_done, m_busy, exp_data}) begin
                n_fail++;
                $display("FAIL random i=%0d: sel/done/busy/data got %h want %h", i,
                         {sel, done, busy, data_out}, {exp_sel, exp_done, m_busy, exp_data});
            end
            mux_i = 4'($urandom);
            start = ($urandom_range(0, 3) == 0);
            cont  = (i < 500) && ($urandom_range(0, 2) == 0);
            dwell = 4'($urandom_range(0, 3));
        end
        start = 1'b0; cont = 1'b0;
        for (int i = 0; i < 40 && busy; i++) @(negedge clk);
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL random_drain: busy=%b want 0 within 40 cycles", busy);
        end
    endtask

    initial begin
        test_reset();
        test_dwell0();
        test_dwell3_toggle();
        test_restart_ignored();
        test_cont();
        test_reset_midscan();
        test_dwell_max();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
